// File: rtl/mem_wb_pkg.sv
// -----------------------------------------------------------------------------
// mem_wb_pkg
// Shared types and constants for the MEM->WB pipeline register.
//   MEM_WB_DATA_W     : data path width used by the stored bundle
//   MEM_WB_REG_ADDR_W : register-index width used by the stored bundle
//   MEM_WB_MAX_STAGES : deepest legal pipeline
//   wb_bundle_t       : one writeback entry as held in a stage register
//   wbResult()        : writeback mux (load data vs. ALU result)
// -----------------------------------------------------------------------------
package mem_wb_pkg;

   localparam int MEM_WB_DATA_W     = 32;
   localparam int MEM_WB_REG_ADDR_W = 5;
   localparam int MEM_WB_MAX_STAGES = 4;

   // reg_write is stored already qualified by valid and WriteReg != 0,
   // so a stored entry with reg_write set always names a real register.
   typedef struct packed {
      logic                         valid;
      logic                         reg_write;
      logic                         mem_to_reg;
      logic [MEM_WB_DATA_W-1:0]     read_data;
      logic [MEM_WB_DATA_W-1:0]     alu_out;
      logic [MEM_WB_REG_ADDR_W-1:0] write_reg;
   } wb_bundle_t;

   function automatic logic [MEM_WB_DATA_W-1:0] wbResult(input wb_bundle_t b);
      return b.mem_to_reg ? b.read_data : b.alu_out;
   endfunction

endpackage

// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
// One writeback-bundle register.
//   clk        in  : clock, rising edge
//   rst        in  : synchronous active-high reset, clears every field
//   hold       in  : keep current contents
//   clearValid in  : drop the valid bit (wins over hold); data fields hold
//   d          in  : next bundle
//   q          out : stored bundle
// -----------------------------------------------------------------------------
module mem_wb_stage
   import mem_wb_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       hold,
   input  logic       clearValid,
   input  wb_bundle_t d,
   output wb_bundle_t q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (clearValid) begin
         // Data is don't-care once invalid; holding it avoids extra muxing.
         q.valid <= 1'b0;
      end else if (!hold) begin
         q <= d;
      end
   end

endmodule

// File: rtl/mem_wb_pipe.sv
// -----------------------------------------------------------------------------
// mem_wb_pipe
// MEM->WB pipeline register for the MIPS core: STAGES bundle registers with
// valid bit, stall, flush, $0-write suppression and a pre-muxed ResultW.
// Optional bypass lookup built when MEM_WB_FWD_EN is defined.
//
// Parameters: DATA_W (<= 32), REG_ADDR_W (<= 5), STAGES (1..4)
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   StallW, FlushW                : hold all stages / invalidate all stages
//   ValidM, RegWriteM, MemtoRegM  : incoming control
//   ReadDataM, ALUOutM, WriteRegM : incoming data and destination
//   ValidW, RegWriteW, MemtoRegW  : output control (RegWriteW qualified)
//   ReadDataW, ALUOutW, ResultW   : output data, ResultW = writeback mux
//   WriteRegW                     : output destination
//   SrcRegA/B, FwdHitA/B, FwdDataA/B : bypass lookup (MEM_WB_FWD_EN only)
//
// Control semantics, highest priority first, applied at each rising edge:
//   rst    -> every entry cleared to 0
//   FlushW -> every entry invalidated (also beats StallW); the bundle on the
//             M inputs in that cycle is dropped
//   StallW -> every entry holds, M inputs are not taken
//   else   -> entry 0 takes the M inputs, entry i takes entry i-1
// Entry 0 is youngest; entry STAGES-1 drives the W outputs.
// -----------------------------------------------------------------------------
module mem_wb_pipe
   import mem_wb_pkg::*;
#(
   parameter int DATA_W     = MEM_WB_DATA_W,
   parameter int REG_ADDR_W = MEM_WB_REG_ADDR_W,
   parameter int STAGES     = 1
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  StallW,
   input  logic                  FlushW,
   input  logic                  ValidM,
   input  logic                  RegWriteM,
   input  logic                  MemtoRegM,
   input  logic [DATA_W-1:0]     ReadDataM,
   input  logic [DATA_W-1:0]     ALUOutM,
   input  logic [REG_ADDR_W-1:0] WriteRegM,
   output logic                  ValidW,
   output logic                  RegWriteW,
   output logic                  MemtoRegW,
   output logic [DATA_W-1:0]     ReadDataW,
   output logic [DATA_W-1:0]     ALUOutW,
   output logic [DATA_W-1:0]     ResultW,
   output logic [REG_ADDR_W-1:0] WriteRegW
`ifdef MEM_WB_FWD_EN
   ,
   input  logic [REG_ADDR_W-1:0] SrcRegA,
   input  logic [REG_ADDR_W-1:0] SrcRegB,
   output logic                  FwdHitA,
   output logic                  FwdHitB,
   output logic [DATA_W-1:0]     FwdDataA,
   output logic [DATA_W-1:0]     FwdDataB
`endif
);

   // Elaboration-time parameter checks.
   if (STAGES < 1 || STAGES > MEM_WB_MAX_STAGES) begin : gBadStages
      $error("mem_wb_pipe: STAGES=%0d outside 1..%0d", STAGES, MEM_WB_MAX_STAGES);
   end
   if (DATA_W < 1 || DATA_W > MEM_WB_DATA_W || REG_ADDR_W < 1 ||
       REG_ADDR_W > MEM_WB_REG_ADDR_W) begin : gBadWidth
      $error("mem_wb_pipe: DATA_W/REG_ADDR_W exceed the stored bundle widths");
   end

   wb_bundle_t                 inBundle;
   wb_bundle_t                 chainIn [STAGES];
   wb_bundle_t                 entry   [STAGES];
   wb_bundle_t                 outEntry;
   logic [MEM_WB_DATA_W-1:0]   outResult;

   // Narrow configurations are zero-extended into the package-width bundle.
   always_comb begin
      inBundle            = '0;
      inBundle.valid      = ValidM;
      inBundle.reg_write  = RegWriteM & ValidM & (WriteRegM != '0);
      inBundle.mem_to_reg = MemtoRegM;
      inBundle.read_data  = MEM_WB_DATA_W'(ReadDataM);
      inBundle.alu_out    = MEM_WB_DATA_W'(ALUOutM);
      inBundle.write_reg  = MEM_WB_REG_ADDR_W'(WriteRegM);
   end

   for (genvar i = 0; i < STAGES; i++) begin : gStage
      if (i == 0) begin : gHead
         assign chainIn[i] = inBundle;
      end else begin : gLink
         assign chainIn[i] = entry[i-1];
      end

      mem_wb_stage uStage (
         .clk        (clk),
         .rst        (rst),
         .hold       (StallW),
         .clearValid (FlushW),
         .d          (chainIn[i]),
         .q          (entry[i])
      );
   end

   assign outEntry  = entry[STAGES-1];
   assign outResult = wbResult(outEntry);

   assign ValidW    = outEntry.valid;
   assign RegWriteW = outEntry.valid & outEntry.reg_write;
   assign MemtoRegW = outEntry.mem_to_reg;
   assign ReadDataW = outEntry.read_data[DATA_W-1:0];
   assign ALUOutW   = outEntry.alu_out[DATA_W-1:0];
   assign ResultW   = outResult[DATA_W-1:0];
   assign WriteRegW = outEntry.write_reg[REG_ADDR_W-1:0];

`ifdef MEM_WB_FWD_EN
   logic [MEM_WB_DATA_W-1:0] entryResult [STAGES];

   for (genvar i = 0; i < STAGES; i++) begin : gFwdRes
      assign entryResult[i] = wbResult(entry[i]);
   end

   // Scan oldest to youngest so a younger match overwrites an older one.
   // Stored reg_write already excludes $0; the explicit zero test keeps a
   // $0 lookup a miss regardless of stored contents.
   always_comb begin
      FwdHitA  = 1'b0;
      FwdHitB  = 1'b0;
      FwdDataA = '0;
      FwdDataB = '0;
      for (int i = STAGES - 1; i >= 0; i--) begin
         if (SrcRegA != '0 && entry[i].valid && entry[i].reg_write &&
             entry[i].write_reg == MEM_WB_REG_ADDR_W'(SrcRegA)) begin
            FwdHitA  = 1'b1;
            FwdDataA = entryResult[i][DATA_W-1:0];
         end
         if (SrcRegB != '0 && entry[i].valid && entry[i].reg_write &&
             entry[i].write_reg == MEM_WB_REG_ADDR_W'(SrcRegB)) begin
            FwdHitB  = 1'b1;
            FwdDataB = entryResult[i][DATA_W-1:0];
         end
      end
   end
`endif

endmodule

// File: doc/mem_wb_pipe.md
# mem_wb_pipe

Parametrised MEM→WB pipeline register for the MIPS core: carries the writeback bundle (control, load data, ALU result and destination register) through `STAGES` register stages. Adds a per-entry valid bit, stall (hold) and flush (kill) control, `$0`-write suppression and a pre-muxed writeback result. Sits between the data-memory stage and the register file. An optional bypass port lets the hazard unit forward from any in-flight entry.

## Interface
Parameters:
- `DATA_W`, 32: width of the data path (ReadData, ALUOut, Result).
- `REG_ADDR_W`, 5: register-index width.
- `STAGES`, 1: number of register stages, legal range 1..4. Out-of-range values are an elaboration error.

Ports:
- `clk`  in  1: the single clock; all state updates on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `StallW`  in  1: hold every stage.
- `FlushW`  in  1: invalidate every stage.
- `ValidM`  in  1: the incoming bundle is real.
- `RegWriteM`  in  1: register-file write enable.
- `MemtoRegM`  in  1: select load data as the result.
- `ReadDataM`  in  DATA_W: load data.
- `ALUOutM`  in  DATA_W: ALU result.
- `WriteRegM`  in  REG_ADDR_W: destination register.
- `ValidW`  out  1: the output entry is valid.
- `RegWriteW`  out  1: qualified write enable (valid, RegWrite set and WriteReg≠0).
- `MemtoRegW`  out  1: registered MemtoReg.
- `ReadDataW`, `ALUOutW`  out  DATA_W: registered data.
- `ResultW`  out  DATA_W: ReadDataW when MemtoRegW is set, otherwise ALUOutW.
- `WriteRegW`  out  REG_ADDR_W: registered destination register.

Bypass ports, present only under `MEM_WB_FWD_EN`:
- `SrcRegA`, `SrcRegB`  in  REG_ADDR_W: source registers to look up.
- `FwdHitA`, `FwdHitB`  out  1: a matching in-flight entry exists.
- `FwdDataA`, `FwdDataB`  out  DATA_W: the result of that entry.

## Operation
- The pipeline is a chain of entries 0..STAGES-1. Entry 0 is youngest (loaded from the M inputs) and entry STAGES-1 drives the W outputs.
- Each cycle the inputs are applied in this priority order:
  - `rst`: every field of every entry becomes 0.
  - `FlushW`: the valid bit of every entry becomes 0. Data fields may load or hold; they are don't-care when invalid. Flush overrides stall.
  - `StallW`: all entries hold their contents unchanged.
  - Otherwise: entry 0 loads the M inputs and entry i loads entry i-1.
- The stored RegWrite is `RegWriteM & ValidM & (WriteRegM != 0)`, so an invalid bundle or a write to `$0` can never cause a register-file write.
- `ResultW` is combinational from the output entry.
- Bypass (`MEM_WB_FWD_EN`), evaluated combinationally and independently for A and B:
  - An entry matches when it is valid, its stored RegWrite is set, and its WriteReg equals the source register.
  - The youngest matching entry wins.
  - `FwdData` carries that entry's mux result. On a miss, `FwdData` is 0.
  - A lookup of source register 0 never hits.

## Timing
- Latency: a bundle accepted at edge n appears on the W outputs after edge n+STAGES-1, i.e. STAGES cycles after it is presented, with no stalls.
- Throughput: one bundle per cycle.
- After reset every output is 0: ValidW, RegWriteW, MemtoRegW, ReadDataW, ALUOutW, ResultW, WriteRegW, FwdHit* and FwdData*.
- A stall held for k cycles delays every entry by k cycles. No bubble is inserted and no entry is duplicated.
- Asserting rst mid-stream discards all in-flight entries at that edge. Asserting rst together with FlushW or StallW gives the reset result.
- A flush takes effect on the edge where it is sampled. A bundle presented in that same cycle is discarded.
- Bypass outputs reflect the register state after the most recent edge. The inputs presented in the current cycle are never forwarded.

## Configuration
- `MEM_WB_FWD_EN` defined: the bypass ports and comparators are built.
- `MEM_WB_FWD_EN` undefined: those ports are absent and no compare logic is generated. Behaviour on all other ports is identical in both builds.

## Structure
- Package `mem_wb_pkg`:
  - constants `MEM_WB_DATA_W=32`, `MEM_WB_REG_ADDR_W=5` and `MEM_WB_MAX_STAGES=4`;
  - packed struct `wb_bundle_t` with fields valid, reg_write, mem_to_reg, read_data, alu_out and write_reg.
- Sub-module `mem_wb_stage`: one bundle register with synchronous reset, hold and clear-valid inputs. The top instantiates it STAGES times and adds the bypass and mux logic.

## Test plan
- Reset, then STAGES=1: present Valid=1, RegWrite=1, MemtoReg=0, ALUOut=0x1234, WriteReg=8 → after the next edge ValidW=1, RegWriteW=1, ResultW=0x1234, WriteRegW=8.
- STAGES=3 with back-to-back bundles ALUOut=1,2,3 → ResultW shows 1,2,3 on cycles 3,4,5. Stall for 2 cycles after the first → outputs shifted by exactly 2 cycles with no duplicates.
- WriteRegM=0 with RegWrite=1, and separately ValidM=0 with RegWrite=1 → RegWriteW=0 in both cases.
- Flush asserted together with stall while 3 entries are in flight (STAGES=3) → ValidW=0 and RegWriteW=0 for the next 3 cycles. Assert rst mid-stream → every output reads 0 at the following edge.
- MemtoReg=1, ReadData=0xDEADBEEF, ALUOut=0x4 → ResultW=0xDEADBEEF.
- `MEM_WB_FWD_EN`, STAGES=2: entries hold reg 5 with 0xAA (older) and reg 5 with 0xBB (younger); SrcRegA=5 → FwdHitA=1, FwdDataA=0xBB. SrcRegB=0 → FwdHitB=0, FwdDataB=0.
